// File: rtl/flow_ctrl_pkg.sv
// flow_ctrl_pkg: state encoding, state width and threshold defaults for flow_ctrl_fsm
package flow_ctrl_pkg;
    localparam int STATE_W = 3;
    localparam int TH_HI_DEFAULT = 6;
    localparam int TH_LO_DEFAULT = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;
endpackage

// File: rtl/flow_ctrl_hyst.sv
// flow_ctrl_hyst: one channel's pause hysteresis with a one-cycle resume pulse on release
module flow_ctrl_hyst #(
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic [LEVEL_W-1:0] th_hi,
    input  logic [LEVEL_W-1:0] th_lo,
    input  logic               upd,
    input  logic               set_on,
    input  logic               clr,
    output logic               pause,
    output logic               resume
);
    logic nxt;
    always_comb nxt = (level >= th_hi) ? 1'b1 : (level <= th_lo) ? 1'b0 : pause;
    // forced clears and sets never produce a resume pulse
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            pause  <= 1'b0;
            resume <= 1'b0;
        end else if (set_on) begin
            pause  <= 1'b1;
            resume <= 1'b0;
        end else if (upd) begin
            pause  <= nxt;
            resume <= pause & ~nxt;
        end else begin
            resume <= 1'b0;
        end
    end
endmodule

// File: rtl/flow_ctrl_fsm.sv
// flow_ctrl_fsm: multi-channel FIFO flow control with hysteresis pause and sticky error handling
// FLOW_CTRL_ERR_CNT_EN adds per-channel 8-bit saturating fifo_error counters on err_cnt.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int LEVEL_W   = 4,
    parameter int TH_HI_DEF = TH_HI_DEFAULT,
    parameter int TH_LO_DEF = TH_LO_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [LEVEL_W-1:0]        th_hi_in,
    input  logic [LEVEL_W-1:0]        th_lo_in,
    input  logic [NUM_CH*LEVEL_W-1:0] fifo_level,
    input  logic [NUM_CH-1:0]         fifo_empty,
    input  logic [NUM_CH-1:0]         fifo_full,
    input  logic [NUM_CH-1:0]         fifo_error,
    input  logic                      err_clear,
    output logic [NUM_CH-1:0]         pause,
    output logic [NUM_CH-1:0]         resume,
    output logic [NUM_CH-1:0]         error_full,
    output logic                      idle,
    output logic [STATE_W-1:0]        state
`ifdef FLOW_CTRL_ERR_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]       err_cnt
`endif
);
    state_t             st, nxt;
    logic [NUM_CH-1:0]  hit;
    logic               work, to_err, upd, clr;
    logic [LEVEL_W-1:0] th_hi, th_lo;

    assign state = st;

    // init outranks error detection, which outranks the all-empty return to IDLE
    always_comb begin
        hit    = fifo_error | fifo_full;
        work   = st == ST_IDLE || st == ST_ACTIVE;
        to_err = work && !init && |hit;
        nxt    = ST_RESET;
        case (st)
            ST_RESET:           nxt = ST_INIT;
            ST_INIT:            nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE, ST_ACTIVE: nxt = init ? ST_INIT : |hit ? ST_ERROR : &fifo_empty ? ST_IDLE : ST_ACTIVE;
            ST_ERROR:           nxt = init ? ST_INIT : err_clear ? ST_IDLE : ST_ERROR;
            default:            nxt = ST_RESET;
        endcase
        upd = st == ST_ACTIVE && nxt == ST_ACTIVE;
        clr = nxt != ST_ACTIVE && nxt != ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st         <= ST_RESET;
            idle       <= 1'b0;
            error_full <= '0;
            th_hi      <= LEVEL_W'(TH_HI_DEF);
            th_lo      <= LEVEL_W'(TH_LO_DEF);
        end else begin
            st         <= nxt;
            idle       <= nxt == ST_IDLE;
            error_full <= nxt == ST_ERROR ? error_full | (to_err ? hit : '0) : '0;
            if (st == ST_INIT && th_lo_in < th_hi_in) begin
                th_hi <= th_hi_in;
                th_lo <= th_lo_in;
            end
        end
    end

`ifdef FLOW_CTRL_ERR_CNT_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset || st == ST_INIT || nxt == ST_INIT)
                err_cnt[i*8 +: 8] <= '0;
            else if (work && fifo_error[i] && err_cnt[i*8 +: 8] != 8'hff)
                err_cnt[i*8 +: 8] <= err_cnt[i*8 +: 8] + 8'd1;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flow_ctrl_hyst #(.LEVEL_W(LEVEL_W)) u_hyst (
            .clk    (clk),
            .reset  (reset),
            .level  (fifo_level[i*LEVEL_W +: LEVEL_W]),
            .th_hi  (th_hi),
            .th_lo  (th_lo),
            .upd    (upd),
            .set_on (to_err),
            .clr    (clr),
            .pause  (pause[i]),
            .resume (resume[i])
        );
    end
endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// tb_flow_ctrl_fsm: randomized scoreboard bench for flow_ctrl_fsm against a behavioural model
module tb_flow_ctrl_fsm;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0, reset = 1'b0, init = 1'b0, err_clear = 1'b0;
    logic [W-1:0]   th_hi_in = '0, th_lo_in = '0;
    logic [N*W-1:0] fifo_level = '0;
    logic [N-1:0]   fifo_empty = '1, fifo_full = '0, fifo_error = '0;
    logic [N-1:0]   pause, resume, error_full;
    logic           idle;
    logic [2:0]     state;
`ifdef FLOW_CTRL_ERR_CNT_EN
    logic [N*8-1:0] err_cnt, cnt_e;
    logic [N*8-1:0] cnt_q[$];
    int             m_cnt[N];
`endif

    flow_ctrl_fsm dut (
        .clk(clk), .reset(reset), .init(init), .th_hi_in(th_hi_in), .th_lo_in(th_lo_in),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_error(fifo_error), .err_clear(err_clear), .pause(pause), .resume(resume),
        .error_full(error_full), .idle(idle), .state(state)
`ifdef FLOW_CTRL_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   st;
        logic         idle;
        logic [N-1:0] ef;
        logic [N-1:0] rs;
        logic [N-1:0] ps;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    obs_t  e, a;
    string t;
    int    total = 0, bad = 0;
    string phase = "reset";

    // behavioural model: state as a plain number (0 RESET .. 4 ERROR), per-channel bits
    int         m_st = 0, m_hi = 6, m_lo = 2;
    bit [N-1:0] m_p, m_r, m_ef;
    bit         m_idle;

    task automatic model_edge();
        bit [N-1:0] hit = fifo_error | fifo_full;
        int nx = m_st;
        m_r = '0;
        if (!reset) begin
            nx = 0; m_p = '0; m_ef = '0; m_hi = 6; m_lo = 2;
        end else if (m_st == 0) begin
            nx = 1;
        end else if (m_st == 1) begin
            if (th_lo_in < th_hi_in) begin m_hi = th_hi_in; m_lo = th_lo_in; end
            nx = init ? 1 : 2;
        end else if (init) begin
            nx = 1; m_p = '0; m_ef = '0;
        end else if (m_st == 4) begin
            if (err_clear) begin nx = 2; m_p = '0; m_ef = '0; end
        end else begin
`ifdef FLOW_CTRL_ERR_CNT_EN
            for (int i = 0; i < N; i++) if (fifo_error[i] && m_cnt[i] < 255) m_cnt[i]++;
`endif
            if (hit != 0) begin
                nx = 4; m_ef |= hit; m_p = '1;
            end else if (fifo_empty == '1) begin
                nx = 2; m_p = '0;
            end else if (m_st == 2) begin
                nx = 3;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int lv = int'(fifo_level[i*W +: W]);
                    bit np = lv >= m_hi ? 1'b1 : lv <= m_lo ? 1'b0 : m_p[i];
                    m_r[i] = m_p[i] && !np;
                    m_p[i] = np;
                end
            end
        end
`ifdef FLOW_CTRL_ERR_CNT_EN
        if (!reset || nx == 1 || m_st == 1) for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        m_st   = nx;
        m_idle = m_st == 2;
    endtask

    task automatic step();
        model_edge();
        exp_q.push_back({3'(m_st), m_idle, m_ef, m_r, m_p});
        tag_q.push_back(phase);
`ifdef FLOW_CTRL_ERR_CNT_EN
        for (int i = 0; i < N; i++) cnt_e[i*8 +: 8] = 8'(m_cnt[i]);
        cnt_q.push_back(cnt_e);
`endif
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, idle, error_full, resume, pause};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s @%0t: got st=%0d idle=%b ef=%b rs=%b ps=%b, want st=%0d idle=%b ef=%b rs=%b ps=%b",
                         t, $time, a.st, a.idle, a.ef, a.rs, a.ps, e.st, e.idle, e.ef, e.rs, e.ps);
            end
`ifdef FLOW_CTRL_ERR_CNT_EN
            cnt_e = cnt_q.pop_front();
            total++;
            if (err_cnt !== cnt_e) begin
                bad++;
                $display("FAIL %s err_cnt @%0t: got %h want %h", t, $time, err_cnt, cnt_e);
            end
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp[7] = '{0, 4, 6, 7, 4, 2, 2};
        step(); step();
        phase = "init_load";
        reset = 1; init = 1; th_hi_in = 5; th_lo_in = 1;
        step(); step();
        init = 0; step(); step();
        phase = "init_bad_th";
        reset = 0; step();
        reset = 1; init = 1; th_hi_in = 2; th_lo_in = 3;
        step(); step();
        init = 0; step(); step();
        phase = "ramp";
        fifo_empty = 4'b1110;
        for (int k = 0; k < 7; k++) begin
            fifo_level[3:0] = 4'(ramp[k]);
            step();
        end
        phase = "error_ch2";
        fifo_error = 4'b0100; step();
        fifo_error = '0; step();
        err_clear = 1; step();
        err_clear = 0; step();
        phase = "full_vs_empty";
        fifo_empty = '1; fifo_full = 4'b0010; step();
        fifo_full = '0; step();
        phase = "reset_in_error";
        reset = 0; step();
        reset = 1; step();
        phase = "random";
        for (int k = 0; k < 3000; k++) begin
            reset     = $urandom_range(0, 199) != 0;
            init      = $urandom_range(0, 39) == 0;
            th_hi_in  = W'($urandom);
            th_lo_in  = W'($urandom);
            for (int i = 0; i < N; i++) begin
                int lv = int'(fifo_level[i*W +: W]) + int'($urandom_range(0, 2)) - 1;
                fifo_level[i*W +: W] = W'(lv < 0 ? 0 : lv > 15 ? 15 : lv);
            end
            fifo_empty = $urandom_range(0, 5) == 0 ? '1 : N'($urandom);
            fifo_full  = $urandom_range(0, 59) == 0 ? N'(1 << $urandom_range(0, N-1)) : '0;
            fifo_error = $urandom_range(0, 39) == 0 ? N'(1 << $urandom_range(0, N-1)) : '0;
            err_clear  = $urandom_range(0, 7) == 0;
            step();
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flow_ctrl_fsm.md
FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Interface
REQ-001 The block SHALL have these parameters:
- NUM_CH, default 4: number of FIFO channels.
- LEVEL_W, default 4: width of each FIFO occupancy value.
- TH_HI_DEF, default 6: reset value of the high threshold.
- TH_LO_DEF, default 2: reset value of the low threshold.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- init  in  1  request to enter INIT and load thresholds.
- th_hi_in  in  LEVEL_W  high threshold, loaded during INIT.
- th_lo_in  in  LEVEL_W  low threshold, loaded during INIT.
- fifo_level  in  NUM_CH*LEVEL_W  per-channel occupancy; channel i at bits [i*LEVEL_W +: LEVEL_W].
- fifo_empty  in  NUM_CH  per-channel empty flag.
- fifo_full  in  NUM_CH  per-channel full flag.
- fifo_error  in  NUM_CH  per-channel overflow/underflow strobe.
- err_clear  in  1  exits ERROR.
- pause  out  NUM_CH  per-channel pause request.
- resume  out  NUM_CH  one-cycle pulse when a pause ends.
- error_full  out  NUM_CH  sticky per-channel error/full flag.
- idle  out  1  high while in IDLE.
- state  out  3  current state encoding.

Function
REQ-003 States and encodings SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-004 All outputs SHALL be registered; each output SHALL reflect its inputs one clock edge later.
REQ-005 RESET SHALL go to INIT on the first edge with reset=1.
REQ-006 In INIT, each edge SHALL load th_hi_in and th_lo_in only if th_lo_in < th_hi_in; otherwise the previous thresholds SHALL be kept.
REQ-007 INIT SHALL go to IDLE on the first edge with init=0.
REQ-008 In IDLE, idle SHALL be 1; if any fifo_empty bit is 0, the block SHALL go to ACTIVE.
REQ-009 In ACTIVE, pause[i] SHALL set when level_i >= th_hi and SHALL clear when level_i <= th_lo.
- Between th_lo and th_hi, pause[i] SHALL hold its value (hysteresis).
- On every 1->0 transition of pause[i], resume[i] SHALL pulse for exactly one cycle.
REQ-010 ACTIVE SHALL go to IDLE when all fifo_empty bits are 1; pause SHALL clear in the same transition with no resume pulse.
REQ-011 In IDLE or ACTIVE, fifo_error[i]=1 or fifo_full[i]=1 SHALL set error_full[i] and go to ERROR.
- Error detection SHALL take priority over the all-empty transition.
REQ-012 In ERROR, pause SHALL be all ones and resume all zeros; err_clear=1 SHALL clear error_full and go to IDLE.
REQ-013 init=1 in IDLE, ACTIVE or ERROR SHALL go to INIT and clear pause, resume and error_full.
- init SHALL take priority over err_clear and over error detection.
REQ-014 Threshold comparisons SHALL be unsigned over LEVEL_W bits; a level equal to a threshold SHALL count as reaching it.

Reset
REQ-015 When reset=0 at a clock edge, the block SHALL load: state=RESET, pause=0, resume=0, error_full=0, idle=0, th_hi=TH_HI_DEF, th_lo=TH_LO_DEF.
REQ-016 Reset SHALL have priority over every other input, including mid-transfer and while in ERROR.

Configuration
REQ-017 When FLOW_CTRL_ERR_CNT_EN is defined, the block SHALL provide an additional output err_cnt (NUM_CH*8).
- err_cnt SHALL hold one 8-bit saturating counter per channel, incremented on each fifo_error[i] strobe in IDLE or ACTIVE.
- The counters SHALL be cleared by reset and by INIT, and SHALL NOT be cleared by err_clear.
REQ-018 When FLOW_CTRL_ERR_CNT_EN is undefined, the err_cnt port and its counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 The package flow_ctrl_pkg SHALL hold the state encodings, the state width and the default threshold constants.
REQ-020 Per-channel hysteresis and resume-pulse logic SHALL be implemented in a sub-module flow_ctrl_hyst, instantiated NUM_CH times with a generate loop.

Verification
REQ-021 Reset, then init=1 with th_hi_in=5 and th_lo_in=1, then init=0 with all FIFOs empty -> state goes RESET->INIT->IDLE, idle=1, and the thresholds loaded are 5 and 1.
REQ-022 init=1 with th_hi_in=2 and th_lo_in=3 -> the thresholds stay at the defaults 6 and 2.
REQ-023 fifo_empty[0]=0, then level0 ramps 0,4,6,7,4,2 -> pause[0]=1 from level 6 until level 2; resume[0] pulses one cycle after the level reaches 2.
REQ-024 In ACTIVE, fifo_error[2]=1 for one cycle -> state=ERROR, error_full=4'b0100, pause=4'b1111; then err_clear=1 -> IDLE with error_full=0.
REQ-025 All FIFOs become empty and fifo_full[1]=1 on the same edge -> state=ERROR, not IDLE.
REQ-026 reset=0 for one edge while in ERROR with pause=4'b1111 -> all outputs are 0 and state=RESET.
